// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the hps_io SD sector port between NREQ drive requesters.
// Latches one request per requester, runs the strobe/ack handshake and returns done/err pulses.
//   state    | meaning
//   IDLE     | no grant; pick next pending requester after rr pointer
//   WAIT_ACK | strobe held, waiting for sd_ack or timeout
//   XFER     | ack high, counting buffer bytes until ack falls
//   FINISH   | one cycle: judge byte count, pulse done/err, release
module sd_sector_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 50000000,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      req_pend,
  output logic [31:0]          sd_lba,
  output logic [NREQ-1:0]      sd_rd,
  output logic [NREQ-1:0]      sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic                 busy,
  output logic [IW-1:0]        buf_sel
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, FINISH} state_t;

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          pend_q, pend_d;
  logic [NREQ-1:0]          dir_q, dir_d;
  logic [NREQ-1:0][31:0]    lba_q, lba_d;
  logic [IW-1:0]            rr_q, rr_d;
  logic [IW-1:0]            gnt_q, gnt_d;
  logic [31:0]              sd_lba_q, sd_lba_d;
  logic [NREQ-1:0]          sd_rd_q, sd_rd_d;
  logic [NREQ-1:0]          sd_wr_q, sd_wr_d;
  logic                     busy_q, busy_d;
  logic [9:0]               cnt_q, cnt_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [NREQ-1:0]          done_q, done_d;
  logic [NREQ-1:0]          err_q, err_d;
  logic                     ack_q;

  logic                     gnt_ok;
  logic [IW-1:0]            gnt_idx;
  logic [IW-1:0]            cand;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!gnt_ok && pend_q[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    lba_d    = lba_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    sd_lba_d = sd_lba_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    done_d   = '0;
    err_d    = '0;

    for (int i = 0; i < NREQ; i++) begin
      if (!pend_q[i] && (req_rd[i] || req_wr[i])) begin
        pend_d[i] = 1'b1;
        dir_d[i]  = req_wr[i];
        lba_d[i]  = req_lba[32*i +: 32];
      end
    end

    case (state_q)
      IDLE: begin
        if (gnt_ok) begin
          sd_lba_d = lba_q[gnt_idx];
          if (dir_q[gnt_idx]) sd_wr_d[gnt_idx] = 1'b1;
          else                sd_rd_d[gnt_idx] = 1'b1;
          gnt_d    = gnt_idx;
          rr_d     = gnt_idx;
          busy_d   = 1'b1;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sd_ack) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          state_d = XFER;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          sd_rd_d        = '0;
          sd_wr_d        = '0;
          err_d[gnt_q]   = 1'b1;
          pend_d[gnt_q]  = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      XFER: begin
        if (sd_buff_wr && cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
        if (ack_q && !sd_ack) state_d = FINISH;
      end
      FINISH: begin
        // Writes never see buffer strobes, so only reads are judged on byte count.
        if (dir_q[gnt_q] || cnt_q == 10'd512) done_d[gnt_q] = 1'b1;
        else                                  err_d[gnt_q]  = 1'b1;
        pend_d[gnt_q] = 1'b0;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      dir_q    <= '0;
      lba_q    <= '0;
      rr_q     <= IW'(NREQ - 1);
      gnt_q    <= '0;
      sd_lba_q <= '0;
      sd_rd_q  <= '0;
      sd_wr_q  <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      lba_q    <= lba_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ack_q    <= sd_ack;
    end
  end

  assign req_done = done_q;
  assign req_err  = err_q;
  assign req_pend = pend_q;
  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign busy     = busy_q;
  assign buf_sel  = busy_q ? gnt_q : '0;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: single read, round robin, timeout,
// short read, collision/ignore and reset mid-transfer.
module tb_sd_sector_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 100;

  logic              clk_sys;
  logic              reset;
  logic [NREQ-1:0]   req_rd, req_wr;
  logic [32*NREQ-1:0] req_lba;
  logic [NREQ-1:0]   req_done, req_err, req_pend;
  logic [31:0]       sd_lba;
  logic [NREQ-1:0]   sd_rd, sd_wr;
  logic              sd_ack, sd_buff_wr, busy;
  logic [1:0]        buf_sel;

  int checks = 0;
  int errors = 0;

  sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_lba    (req_lba),
    .req_done   (req_done),
    .req_err    (req_err),
    .req_pend   (req_pend),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_ack     (sd_ack),
    .sd_buff_wr (sd_buff_wr),
    .busy       (busy),
    .buf_sel    (buf_sel)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Waits for a strobe, checks it, acks after ack_dly cycles, sends nbytes, drops ack.
  task automatic serve(input string tag, input int ack_dly, input int nbytes,
                       input logic [2:0] extra_rd, input logic [2:0] exp_rd,
                       input logic [2:0] exp_wr, output logic [31:0] lba,
                       output logic [1:0] bsel, output int waited,
                       output logic [2:0] done, output logic [2:0] err);
    lba = '0; bsel = '0; waited = 0; done = '0; err = '0;
    while ((sd_rd | sd_wr) == 0 && waited < 50) begin
      tick();
      waited++;
    end
    if ((sd_rd | sd_wr) == 0) begin
      check_val({tag, "_strobe_seen"}, 0, 1);
      return;
    end
    check_val({tag, "_strobe"}, {sd_rd, sd_wr}, {exp_rd, exp_wr});
    check_val({tag, "_busy"}, busy, 1);
    lba  = sd_lba;
    bsel = buf_sel;
    for (int i = 0; i < ack_dly; i++) tick();
    if (ack_dly > 0) check_val({tag, "_strobe_held"}, {sd_rd, sd_wr}, {exp_rd, exp_wr});
    req_rd = extra_rd;
    sd_ack = 1'b1;
    tick();
    req_rd = '0;
    check_val({tag, "_strobe_drop"}, {sd_rd, sd_wr}, 0);
    for (int i = 0; i < nbytes; i++) begin
      sd_buff_wr = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    tick();
    done = req_done;
    err  = req_err;
  endtask

  logic [31:0] lba;
  logic [1:0]  bsel;
  logic [2:0]  done, err;
  logic [2:0]  seen;
  int          waited, cnt;

  initial begin
    do_reset();
    check_val("reset_ctrl", {req_done, req_err, req_pend, sd_rd, sd_wr, busy, buf_sel}, 0);
    check_val("reset_lba", sd_lba, 0);

    // Single read on requester 1
    req_rd = 3'b010; req_lba[63:32] = 32'h0000_1234;
    tick();
    req_rd = '0;
    check_val("rd1_pend", req_pend, 3'b010);
    check_val("rd1_t1_nostrobe", sd_rd, 0);
    serve("rd1", 4, 512, 3'b000, 3'b010, 3'b000, lba, bsel, waited, done, err);
    check_val("rd1_latency", waited, 1);
    check_val("rd1_lba", lba, 32'h0000_1234);
    check_val("rd1_bsel", bsel, 1);
    check_val("rd1_done", done, 3'b010);
    check_val("rd1_err", err, 0);
    check_val("rd1_idle", {busy, req_pend}, 0);
    tick();
    check_val("rd1_done_pulse", req_done, 0);
    check_val("rd1_lba_hold", sd_lba, 32'h0000_1234);

    // Round robin from reset: 0,1,2 then 1 alone, then 0 and 2 -> 2,0
    do_reset();
    req_rd = 3'b101; req_wr = 3'b010;
    req_lba = {32'hC2, 32'hB1, 32'hA0};
    tick();
    req_rd = '0; req_wr = '0;
    serve("rr0", 0, 512, 3'b000, 3'b001, 3'b000, lba, bsel, waited, done, err);
    check_val("rr0_lba", lba, 32'hA0);
    check_val("rr0_done", done, 3'b001);
    serve("rr1", 0, 0, 3'b000, 3'b000, 3'b010, lba, bsel, waited, done, err);
    check_val("rr1_lba", lba, 32'hB1);
    check_val("rr1_bsel", bsel, 1);
    check_val("rr1_done", done, 3'b010);
    serve("rr2", 0, 512, 3'b000, 3'b100, 3'b000, lba, bsel, waited, done, err);
    check_val("rr2_lba", lba, 32'hC2);
    check_val("rr2_done", done, 3'b100);
    req_rd = 3'b010; req_lba[63:32] = 32'hB2;
    tick();
    req_rd = '0;
    serve("rr3", 0, 512, 3'b000, 3'b010, 3'b000, lba, bsel, waited, done, err);
    check_val("rr3_done", done, 3'b010);
    req_rd = 3'b101; req_lba = {32'hC3, 32'hB2, 32'hA3};
    tick();
    req_rd = '0;
    serve("rr4", 0, 512, 3'b000, 3'b100, 3'b000, lba, bsel, waited, done, err);
    check_val("rr4_lba", lba, 32'hC3);
    serve("rr5", 0, 512, 3'b000, 3'b001, 3'b000, lba, bsel, waited, done, err);
    check_val("rr5_lba", lba, 32'hA3);
    check_val("rr5_done", done, 3'b001);

    // Timeout on write 0 with no ack; requester 1 queued meanwhile
    req_wr = 3'b001; req_lba[31:0] = 32'h77;
    tick();
    req_wr = '0;
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      req_rd = (n == 5) ? 3'b010 : 3'b000;
      tick();
      if (sd_wr[0]) cnt++;
      else if (cnt > 0) break;
    end
    req_rd = '0;
    check_val("to_len", cnt, TIMEOUT);
    check_val("to_err", req_err, 3'b001);
    check_val("to_done", req_done, 0);
    check_val("to_busy", busy, 0);
    check_val("to_pend", req_pend, 3'b010);
    serve("to_next", 0, 512, 3'b000, 3'b010, 3'b000, lba, bsel, waited, done, err);
    check_val("to_next_done", done, 3'b010);

    // Short read on requester 2
    req_rd = 3'b100; req_lba[95:64] = 32'h300;
    tick();
    req_rd = '0;
    serve("short", 0, 300, 3'b000, 3'b100, 3'b000, lba, bsel, waited, done, err);
    check_val("short_err", err, 3'b100);
    check_val("short_done", done, 0);

    // Collision: rd+wr together -> write; repeat rd during transfer ignored
    req_rd = 3'b001; req_wr = 3'b001; req_lba[31:0] = 32'hABCD;
    tick();
    req_rd = '0; req_wr = '0;
    serve("coll", 0, 0, 3'b001, 3'b000, 3'b001, lba, bsel, waited, done, err);
    check_val("coll_lba", lba, 32'hABCD);
    check_val("coll_done", done, 3'b001);
    check_val("coll_pend", req_pend, 0);
    seen = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      seen = seen | sd_rd | sd_wr;
    end
    check_val("coll_no_second", seen, 0);

    // Reset during XFER after 100 bytes
    req_rd = 3'b110; req_lba = {32'h22, 32'h11, 32'h0};
    tick();
    req_rd = '0;
    waited = 0;
    while ((sd_rd | sd_wr) == 0 && waited < 50) begin
      tick();
      waited++;
    end
    check_val("rst_strobe", sd_rd, 3'b010);
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      sd_buff_wr = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    reset = 1'b1;
    tick();
    check_val("rst_ctrl", {req_done, req_err, req_pend, sd_rd, sd_wr, busy, buf_sel}, 0);
    check_val("rst_lba", sd_lba, 0);
    reset = 1'b0;
    sd_ack = 1'b0;
    seen = '0;
    for (int n = 0; n < 8; n++) begin
      tick();
      seen = seen | req_done | req_err | req_pend | sd_rd | sd_wr;
    end
    check_val("rst_quiet", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single hps_io SD sector port (sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_wr) between NREQ independent drive requesters, e.g. D1, D2 and the cart slot.
- Latches single-cycle read/write requests with their LBA and grants them round-robin.
- Runs the strobe/ack handshake, counts buffer bytes on reads, and returns a per-requester done or error pulse.
- Sits between the ZPU disk-I/O glue and hps_io; buf_sel steers the shared 512-byte sector buffer mux.

Parameters:
- NREQ, 3, number of requesters / SD image slots.
- TIMEOUT, 50000000, clk_sys cycles allowed from strobe assertion to sd_ack rise before abort.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_rd  in  NREQ  per-requester one-cycle read request pulse.
- req_wr  in  NREQ  per-requester one-cycle write request pulse.
- req_lba  in  32*NREQ  LBA for requester i in bits [32i+31:32i]; sampled with the request pulse.
- req_done  out  NREQ  one-cycle pulse, transfer completed OK.
- req_err  out  NREQ  one-cycle pulse, transfer aborted (timeout or short read).
- req_pend  out  NREQ  request latched or in service.
- sd_lba  out  32  LBA to hps_io.
- sd_rd  out  NREQ  read strobe to hps_io, one bit per image.
- sd_wr  out  NREQ  write strobe to hps_io, one bit per image.
- sd_ack  in  1  hps_io acknowledge, high for the whole transfer.
- sd_buff_wr  in  1  hps_io buffer byte-write strobe.
- busy  out  1  a transfer is granted.
- buf_sel  out  $clog2(NREQ)  granted requester index; valid while busy.

Behaviour:
- Reset: all outputs 0; pending bits cleared; state IDLE; rr pointer = NREQ-1, so requester 0 has first priority.
- Latching: req_rd[i] or req_wr[i] with req_pend[i]=0 sets pend[i], sets dir[i] (1=write), and stores req_lba slice i.
- Both req_rd[i] and req_wr[i] in the same cycle: write wins.
- Any request to a requester with req_pend[i]=1 is ignored; no state change.
- States: IDLE, WAIT_ACK, XFER, FINISH.
- IDLE:
  - Search pend[] from rr+1, wrapping modulo NREQ; first set bit g is granted.
  - At that edge: sd_lba<=lba[g]; sd_rd[g] or sd_wr[g]<=1 (dir[g]); buf_sel<=g; busy<=1; rr<=g; byte counter<=0; timeout counter<=0; go to WAIT_ACK.
  - Latency: request pulse in cycle t gives a visible strobe in cycle t+2.
- WAIT_ACK:
  - Strobe held.
  - When sd_ack=1 is sampled: clear the strobe on that edge and go to XFER.
  - If the timeout counter reaches TIMEOUT-1 without ack: clear the strobe, pulse req_err[g], clear pend[g] and busy, go to IDLE.
- XFER:
  - Each sd_buff_wr increments the 10-bit byte counter, saturating at 1023.
  - On sd_ack falling, i.e. previous registered ack=1 and current 0, go to FINISH.
- FINISH, one cycle:
  - Read: counter==512 pulses req_done[g]; any other count pulses req_err[g].
  - Write: req_done[g] always.
  - Clear pend[g] and busy; go to IDLE.
  - A new grant can start on the edge after FINISH, so there is at least one idle cycle between strobes.
- sd_rd and sd_wr are one-hot or zero; never more than one bit set across both vectors.
- sd_lba holds its value until the next grant.
- sd_ack high while in IDLE (stale) is ignored; a grant is still issued.
  - If ack is still high when the next WAIT_ACK is entered, it is taken as the acknowledge.
- A request from the granted requester arriving during its own transfer is ignored (pend still 1).
- Requests to other requesters during a transfer are latched and served in round-robin order.
- Reset mid-transfer: strobes drop on the next edge; no done/err pulse; all pending requests are discarded.

Test Plan:
- Single read: req_rd[1] pulse with LBA 0x00001234, ack after 5 cycles, 512 sd_buff_wr pulses, ack falls -> sd_rd=3'b010 from t+2 until the edge after ack; sd_lba=0x1234; buf_sel=1; req_done=3'b010 one cycle; req_err=0.
- Round robin: req_rd[0], req_wr[1] and req_rd[2] in the same cycle, each transfer acked -> service order 0,1,2; then a second request on 0 and 2 gives order 2,0 only if the last grant was 1 (rr check with pointer=1: grant 2 then 0).
- Timeout: TIMEOUT=100, req_wr[0], sd_ack never rises -> sd_wr[0] high for exactly 100 cycles; req_err[0] pulse; busy=0; next pending request granted.
- Short read: req_rd[2], ack high, only 300 sd_buff_wr pulses, ack falls -> req_err[2] pulse, no req_done.
- Collision/ignore: req_rd[0] and req_wr[0] together -> a write is issued; a repeat req_rd[0] during the transfer -> no second transfer; req_pend[0] clears after FINISH.
- Reset mid-XFER after 100 bytes -> all outputs 0 the next cycle; no done/err pulse; pending requests cleared.
